// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU: opcode constants, branch-control
// encodings, scoreboard entry layout and operand-use decode.
package cpu_pkg;

  localparam int PC_W_DEF = 9;

  localparam logic [4:0] ALU  = 5'b00110;
  localparam logic [4:0] ALUI = 5'b00100;
  localparam logic [4:0] LW   = 5'b00010;
  localparam logic [4:0] SW   = 5'b00011;
  localparam logic [4:0] BEZ  = 5'b10000;
  localparam logic [4:0] BNEZ = 5'b01000;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BNEZ = 2'b01,
    BR_BEZ  = 2'b10
  } br_ctrl_e;

  typedef struct packed {
    logic       wr;
    logic [2:0] rd;
  } sb_entry_t;

  function automatic logic usesRs1(input logic [4:0] op);
    return (op == ALU) || (op == ALUI) || (op == LW) || (op == SW) ||
           (op == BEZ) || (op == BNEZ);
  endfunction

  function automatic logic usesRs2(input logic [4:0] op);
    return (op == ALU) || (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes for EX/MEM/WB and raises stall when the
// instruction in ID reads a register that has not yet been written back.
module hazard_scoreboard
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid_i,
  input  logic       flush_i,
  input  logic [4:0] id_op_i,
  input  logic [2:0] id_rd_i,
  input  logic [2:0] id_rs1_i,
  input  logic [2:0] id_rs2_i,
  input  logic       id_wr_i,
  output logic       stall_o,
  output logic       issue_o,
  output logic       busy_o
);

  sb_entry_t  sbEx_q, sbMem_q, sbWb_q, sbEx_d;
  logic [2:0] live_q;
  logic       useRs1, useRs2, rawHit;

  function automatic logic hits(input sb_entry_t e, input logic [2:0] rs,
                                input logic used);
    return used & e.wr & (e.rd == rs);
  endfunction

  assign useRs1 = usesRs1(id_op_i);
  assign useRs2 = usesRs2(id_op_i);

  // No forwarding and no register-file bypass, so WB still counts as a hazard.
  always_comb begin
    rawHit = hits(sbEx_q,  id_rs1_i, useRs1) | hits(sbEx_q,  id_rs2_i, useRs2) |
             hits(sbMem_q, id_rs1_i, useRs1) | hits(sbMem_q, id_rs2_i, useRs2) |
             hits(sbWb_q,  id_rs1_i, useRs1) | hits(sbWb_q,  id_rs2_i, useRs2);
  end

  assign stall_o = id_valid_i & ~flush_i & rawHit;
  assign issue_o = id_valid_i & ~stall_o & ~flush_i;

  always_comb begin
    sbEx_d = '0;
    if (issue_o) sbEx_d = {id_wr_i, id_rd_i};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbEx_q  <= '0;
      sbMem_q <= '0;
      sbWb_q  <= '0;
      live_q  <= '0;
    end else begin
      sbEx_q  <= sbEx_d;
      sbMem_q <= sbEx_q;
      sbWb_q  <= sbMem_q;
      live_q  <= {live_q[1:0], issue_o};
    end
  end

  assign busy_o = id_valid_i | sbEx_q.wr | sbMem_q.wr | sbWb_q.wr | (|live_q);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: owns the fetch PC, the IF/ID valid bit and taken-branch
// flush; RAW hazard tracking is delegated to hazard_scoreboard.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  input  logic [4:0]      id_op,
  input  logic [2:0]      id_rd,
  input  logic [2:0]      id_rs1,
  input  logic [2:0]      id_rs2,
  input  logic [1:0]      id_wb_ctrl,
  input  logic [1:0]      ex_br_ctrl,
  input  logic            ex_rs1_zero,
  input  logic [PC_W-1:0] ex_br_target,
  output logic [PC_W-1:0] pc,
  output logic            imem_en,
  output logic            id_valid,
  output logic            stall,
  output logic            flush,
  output logic            id_ex_bubble,
  output logic            busy
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            idValid_q, idValid_d;
  logic            issue;
  logic            unusedWbHi;

  assign unusedWbHi = id_wb_ctrl[1];

  assign flush = ((ex_br_ctrl == BR_BEZ)  &  ex_rs1_zero) |
                 ((ex_br_ctrl == BR_BNEZ) & ~ex_rs1_zero);

  hazard_scoreboard u_sb (
    .clk        (clk),
    .reset      (reset),
    .id_valid_i (idValid_q),
    .flush_i    (flush),
    .id_op_i    (id_op),
    .id_rd_i    (id_rd),
    .id_rs1_i   (id_rs1),
    .id_rs2_i   (id_rs2),
    .id_wr_i    (id_wb_ctrl[0]),
    .stall_o    (stall),
    .issue_o    (issue),
    .busy_o     (busy)
  );

  // A taken branch outranks everything, including a stall in the same cycle.
  always_comb begin
    pc_d = pc_q;
    if (flush)                pc_d = ex_br_target;
    else if (!run && pc_load) pc_d = pc_load_val;
    else if (run && !stall)   pc_d = pc_q + 1'b1;
  end

  assign idValid_d = (run & ~flush) | (idValid_q & stall);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      idValid_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      idValid_q <= idValid_d;
    end
  end

  assign pc           = pc_q;
  assign id_valid     = idValid_q;
  assign imem_en      = (run & ~stall) | flush;
  assign id_ex_bubble = ~issue;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes cycle-tagged expectations into
// a queue that a negedge monitor pops and compares against the outputs.
module tb_pipe_ctrl;
  import cpu_pkg::*;

  localparam int PCW = 9;
  localparam logic [4:0] NOP = 5'b00000;

  logic           clk = 1'b0;
  logic           reset;
  logic           run;
  logic           pc_load;
  logic [PCW-1:0] pc_load_val;
  logic [4:0]     id_op;
  logic [2:0]     id_rd, id_rs1, id_rs2;
  logic [1:0]     id_wb_ctrl;
  logic [1:0]     ex_br_ctrl;
  logic           ex_rs1_zero;
  logic [PCW-1:0] ex_br_target;
  logic [PCW-1:0] pc;
  logic           imem_en, id_valid, stall, flush, id_ex_bubble, busy;

  always #5 clk = ~clk;

  pipe_ctrl #(.PC_W(PCW)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .pc_load      (pc_load),
    .pc_load_val  (pc_load_val),
    .id_op        (id_op),
    .id_rd        (id_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_wb_ctrl   (id_wb_ctrl),
    .ex_br_ctrl   (ex_br_ctrl),
    .ex_rs1_zero  (ex_rs1_zero),
    .ex_br_target (ex_br_target),
    .pc           (pc),
    .imem_en      (imem_en),
    .id_valid     (id_valid),
    .stall        (stall),
    .flush        (flush),
    .id_ex_bubble (id_ex_bubble),
    .busy         (busy)
  );

  // Packed layout: {pc[8:0], imem_en, id_valid, stall, flush, bubble, busy}.
  typedef struct {
    int          cyc;
    string       name;
    logic [14:0] val;
    logic [14:0] mask;
  } exp_t;

  exp_t expQ[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic pushExpect(input string name, input int pcE, input int imemE,
                            input int idvE, input int stallE, input int flushE,
                            input int bubE, input int busyE);
    exp_t e;
    int   bits[6];
    e.cyc  = cyc;
    e.name = name;
    e.val  = '0;
    e.mask = '0;
    if (pcE >= 0) begin
      e.val[14:6]  = pcE[8:0];
      e.mask[14:6] = '1;
    end
    bits = '{imemE, idvE, stallE, flushE, bubE, busyE};
    for (int i = 0; i < 6; i++) begin
      if (bits[i] >= 0) begin
        e.val[5-i]  = bits[i][0];
        e.mask[5-i] = 1'b1;
      end
    end
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e, input logic [14:0] act);
    checks++;
    if (cyc != e.cyc || (act & e.mask) !== (e.val & e.mask)) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d (due %0d): got pc=%03h imem_en=%b id_valid=%b stall=%b flush=%b bubble=%b busy=%b, required bits %015b under mask %015b",
               e.name, cyc, e.cyc, act[14:6], act[5], act[4], act[3], act[2],
               act[1], act[0], e.val & e.mask, e.mask);
    end
  endtask

  always @(negedge clk) begin
    logic [14:0] act;
    exp_t        e;
    act = {pc, imem_en, id_valid, stall, flush, id_ex_bubble, busy};
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      e = expQ.pop_front();
      checkOutput(e, act);
    end
  end

  task automatic applyStimulus(input logic runV, input logic [4:0] op,
                               input logic [2:0] rd, input logic [2:0] rs1,
                               input logic [2:0] rs2, input logic [1:0] wb);
    @(posedge clk);
    #1;
    run          = runV;
    id_op        = op;
    id_rd        = rd;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_wb_ctrl   = wb;
    pc_load      = 1'b0;
    pc_load_val  = '0;
    ex_br_ctrl   = 2'b00;
    ex_rs1_zero  = 1'b0;
    ex_br_target = '0;
  endtask

  initial begin
    reset        = 1'b1;
    run          = 1'b0;
    pc_load      = 1'b0;
    pc_load_val  = '0;
    id_op        = NOP;
    id_rd        = '0;
    id_rs1       = '0;
    id_rs2       = '0;
    id_wb_ctrl   = '0;
    ex_br_ctrl   = '0;
    ex_rs1_zero  = 1'b0;
    ex_br_target = '0;

    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    pushExpect("reset_state", 0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    reset = 1'b0;
    pushExpect("run_start", 0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    pushExpect("first_fetch_in_id", 1, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    reset = 1'b1;
    pushExpect("reset_mid_run", 0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    reset = 1'b0;
    pushExpect("after_reset", 0, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    pushExpect("refetch", 1, 1, 1, 0, 0, 0, 1);

    // ALU r3 <- r1,r2 then ALU reading r3 as rs2 directly behind it.
    applyStimulus(1, ALU, 3, 1, 2, 2'b01);
    pushExpect("alu_producer", 2, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, ALU, 4, 1, 3, 2'b01);
      pushExpect("raw_rs2_stall", 3, 0, 1, 1, 0, 1, 1);
    end
    applyStimulus(1, ALU, 4, 1, 3, 2'b01);
    pushExpect("raw_rs2_issue", 3, 1, 1, 0, 0, 0, 1);

    applyStimulus(1, ALUI, 5, 1, 4, 2'b01);
    pushExpect("alui_rs2_unused", 4, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, LW, 2, 0, 0, 2'b01);
    pushExpect("lw_issue", 5, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, SW, 0, 2, 6, 2'b00);
      pushExpect("sw_after_lw_stall", 6, 0, 1, 1, 0, 1, 1);
    end
    applyStimulus(1, SW, 0, 2, 6, 2'b00);
    pushExpect("sw_issue", 6, 1, 1, 0, 0, 0, 1);

    // BEZ taken in EX; the ALU writing r6 in ID is discarded.
    applyStimulus(1, ALU, 6, 1, 1, 2'b01);
    ex_br_ctrl   = 2'b10;
    ex_rs1_zero  = 1'b1;
    ex_br_target = 9'h040;
    pushExpect("bez_flush", 7, 1, 1, 0, 1, 1, 1);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    pushExpect("bez_second_bubble", 9'h040, 1, 0, 0, 0, 1, 1);
    applyStimulus(1, ALU, 7, 6, 6, 2'b00);
    pushExpect("target_in_id_no_sb_entry", 9'h041, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    ex_br_ctrl  = 2'b01;
    ex_rs1_zero = 1'b1;
    pushExpect("bnez_not_taken", 9'h042, 1, 1, 0, 0, 0, 1);

    // Stall on r1 is pre-empted by a taken BNEZ.
    applyStimulus(1, ALU, 1, 0, 0, 2'b01);
    pushExpect("r1_producer", 9'h043, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, ALU, 2, 1, 0, 2'b01);
    pushExpect("r1_stall", 9'h044, 0, 1, 1, 0, 1, 1);
    applyStimulus(1, ALU, 2, 1, 0, 2'b01);
    ex_br_ctrl   = 2'b01;
    ex_rs1_zero  = 1'b0;
    ex_br_target = 9'h100;
    pushExpect("flush_beats_stall", 9'h044, 1, 1, 0, 1, 1, 1);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    pushExpect("held_instr_dropped", 9'h100, 1, 0, 0, 0, 1, 1);
    applyStimulus(1, ALU, 3, 2, 2, 2'b00);
    pushExpect("held_never_issued", 9'h101, 1, 1, 0, 0, 0, 1);

    // Stop, load 0x1FE, drain, then run across the wrap.
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    pc_load     = 1'b1;
    pc_load_val = 9'h1FE;
    pushExpect("load_while_idle", 9'h102, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    pushExpect("load_done", 9'h1FE, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    pushExpect("drained_idle", 9'h1FE, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    pushExpect("wrap_1fe", 9'h1FE, 1, 0, 0, 0, 1, 0);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    pushExpect("wrap_1ff", 9'h1FF, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, NOP, 0, 0, 0, 2'b00);
    pushExpect("wrap_000", 9'h000, 1, 1, 0, 0, 0, 1);

    // Last fetch was at pc=0; busy holds for 4 cycles then drops.
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    pushExpect("drain_start", 9'h001, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    pushExpect("drain_in_wb", 9'h001, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    pushExpect("drain_done", 9'h001, 0, 0, 0, 0, 1, 0);

    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    applyStimulus(0, NOP, 0, 0, 0, 2'b00);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s never compared: got no sample, required a sample at cycle %0d",
               e.name, e.cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
